// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: sending end of a 2-phase (toggle) req/ack CDC handshake.
// Define CDC_HS_TX_TIMEOUT_EN to build in the o_timeout ack watchdog.
module cdc_hs_tx #(
  parameter int Width         = 8,
  parameter int NSync         = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [Width-1:0] i_data,
  output logic             o_ready,
  output logic             o_req,
  output logic [Width-1:0] o_data,
`ifdef CDC_HS_TX_TIMEOUT_EN
  output logic             o_timeout,
`endif
  input  logic             i_ack
);

  localparam logic IDLE     = 1'b0;
  localparam logic WAIT_ACK = 1'b1;

  if (Width < 1 || NSync < 2 || TimeoutCycles < 2) begin : g_bad_cfg
    $error("cdc_hs_tx: illegal parameter set");
  end

  logic             state;
  logic             state_nx;
  logic [NSync-1:0] sync;
  logic             ack_s;
  logic             accept;
  logic             done;

  // i_ack is asynchronous to clk; only ack_s may be used
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[NSync-2:0], i_ack};
    end
  end

  assign ack_s  = sync[NSync-1];
  assign accept = i_valid & o_ready;
  assign done   = (state == WAIT_ACK) & (ack_s == o_req);

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      accept:  state_nx = WAIT_ACK;
      done:    state_nx = IDLE;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      o_ready <= 1'b1;
    end else begin
      state   <= state_nx;
      o_ready <= (state_nx == IDLE);
    end
  end

  // Payload and request only move on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_req  <= 1'b0;
      o_data <= '0;
    end else if (accept) begin
      o_req  <= ~o_req;
      o_data <= i_data;
    end
  end

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TMAX = TW'(TimeoutCycles);

  logic [TW-1:0] cnt;

  // Sticky flag; the handshake itself keeps waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      o_timeout <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == WAIT_ACK && cnt != TMAX) begin
      cnt <= cnt + 1'b1;
      if (cnt == TMAX - 1'b1) begin
        o_timeout <= 1'b1;
      end
    end
  end
`endif

endmodule
